failover_tx_mux: RTL and testbench
==================================

FAILOVER_TX_MUX -- requirements
Module: failover_tx_mux

Interface
REQ-001 Parameters SHALL be: IPG_CYCLES, default 12, minimum idle cycles after a source switch; MAX_FRAME_CYCLES, default 1530, longest legal frame including preamble.
REQ-002 clk  input  1  GMII byte clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 sel_p1  input  1  requested source, 1 = port 1, 0 = port 2; level, may toggle at any cycle.
REQ-005 p1_data/p1_en/p1_er  input  8/1/1  port-1 GMII byte stream from its receive FIFO; no backpressure.
REQ-006 p2_data/p2_en/p2_er  input  8/1/1  port-2 GMII byte stream, same rules.
REQ-007 tx_data/tx_en/tx_er  output  8/1/1  merged upstream GMII transmit stream, registered.
REQ-008 active_p1  output  1  source currently granted, 1 = port 1.
REQ-009 switched  output  1  one-cycle pulse when the active source changes.
REQ-010 truncated  output  1  one-cycle pulse when a frame is cut at MAX_FRAME_CYCLES.

Function
REQ-011 Output latency SHALL be exactly one clk cycle from the selected input byte to tx_*.
REQ-012 FSM states SHALL be IDLE, PASS, DRAIN, GAP, ABORT.
REQ-013 IDLE: tx_en=0, tx_er=0, tx_data=0; a rising edge of the active source's en (en=1 with previous en=0) SHALL enter PASS and forward that byte.
REQ-014 PASS: forward data/en/er of the active source; en low SHALL return to IDLE in the same cycle (tx_en=0 on that output).
REQ-015 A change of sel_p1 during PASS SHALL be deferred; it takes effect only once the FSM is back in IDLE.
REQ-016 In IDLE with sel_p1 != active_p1: toggle active_p1, pulse switched, load the gap counter with IPG_CYCLES, then go to DRAIN if the new source's en=1, otherwise to GAP.
REQ-017 DRAIN: output idle and discard the new source until its en=0; then GAP. A frame already in progress SHALL never be forwarded partially.
REQ-018 GAP: output idle; the counter decrements each cycle with new-source en=0; a new-source en=1 before zero SHALL go to DRAIN and reload the counter; at zero go to IDLE.
REQ-019 A sel_p1 change back during DRAIN or GAP SHALL be taken on the next IDLE visit, never mid-GAP.
REQ-020 The frame-length counter SHALL count PASS cycles, sized to clog2(MAX_FRAME_CYCLES+1) bits, saturating, cleared on PASS entry.
REQ-021 On the cycle the count reaches MAX_FRAME_CYCLES: output tx_en=1, tx_er=1, pulse truncated, enter ABORT.
REQ-022 ABORT: output idle until the source's en=0, then IDLE.
REQ-023 The inactive source SHALL be ignored entirely; its er has no effect on the output.
REQ-024 er on the active source during PASS SHALL pass through unchanged.

Reset
REQ-025 On rst=1: FSM=IDLE, tx_data=0, tx_en=0, tx_er=0, active_p1=1, switched=0, truncated=0, both counters 0, previous-en registers 0.
REQ-026 rst asserted mid-frame SHALL force tx_en=0 on the following cycle.
REQ-027 After rst release, a source whose en is already 1 SHALL NOT be forwarded until it has been seen low (no edge).

Structure
REQ-028 State encoding and the IPG_CYCLES/MAX_FRAME_CYCLES defaults SHALL live in the shared ethernet package.
REQ-029 The block SHALL be a single module with no sub-modules; the input mux is combinational and feeds one output register stage.

Verification
REQ-030 Port-1 frame of 64 bytes, sel_p1=1 -> identical 64 bytes on tx_* one cycle later, switched=0.
REQ-031 sel_p1 falls at byte 20 of a 100-byte port-1 frame -> all 100 bytes forwarded, then switched pulses and active_p1=0.
REQ-032 Switch to port 2 while a port-2 frame is at byte 30 -> that frame fully suppressed, a 12-cycle idle follows, and the next port-2 frame is forwarded whole.
REQ-033 Port-2 frame starts 5 cycles into GAP -> frame discarded, counter reloads, tx_en stays 0 throughout.
REQ-034 Continuous p1_en for 2000 cycles -> tx_er=1 at output cycle 1530, truncated pulses once, and tx_en=0 until p1_en falls.
REQ-035 rst pulsed at byte 10 of a frame -> tx_en=0 next cycle, active_p1=1, and no output until the next clean rising edge of en.

Source files
------------

// File: rtl/failover_tx_mux_pkg.sv
// Shared definitions for the failover GMII transmit mux: FSM encoding and
// default timing parameters.
package failover_tx_mux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PASS  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_GAP   = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam int IPG_CYCLES_DEF       = 12;
    localparam int MAX_FRAME_CYCLES_DEF = 1530;

endpackage

// File: rtl/failover_tx_mux.sv
// Merges two GMII receive streams onto one upstream transmit port, switching
// only between frames and never forwarding a partial frame.
//
// state | meaning
// IDLE  | no frame; wait for a clean rising en on the active source or a switch
// PASS  | forwarding the active source byte-for-byte
// DRAIN | new source was mid-frame at switch time; discard until its en drops
// GAP   | counting out the inter-packet gap on the new source
// ABORT | frame was cut at the length limit; hold idle until en drops
module failover_tx_mux
    import failover_tx_mux_pkg::*;
#(
    parameter int IPG_CYCLES       = IPG_CYCLES_DEF,
    parameter int MAX_FRAME_CYCLES = MAX_FRAME_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sel_p1,
    input  logic [7:0] p1_data,
    input  logic       p1_en,
    input  logic       p1_er,
    input  logic [7:0] p2_data,
    input  logic       p2_en,
    input  logic       p2_er,
    output logic [7:0] tx_data,
    output logic       tx_en,
    output logic       tx_er,
    output logic       active_p1,
    output logic       switched,
    output logic       truncated
);

    localparam int FW = $clog2(MAX_FRAME_CYCLES + 1);
    localparam int GW = (IPG_CYCLES < 1) ? 1 : $clog2(IPG_CYCLES + 1);

    localparam logic [FW-1:0] FRAME_MAX  = FW'(MAX_FRAME_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST = FW'(MAX_FRAME_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(IPG_CYCLES);
    localparam logic [GW-1:0] GAP_ONE    = GW'(1);

    state_t          state;
    logic [FW-1:0]   frame_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            p1_prev;
    logic            p2_prev;
    logic            p1_armed;
    logic            p2_armed;

    logic [7:0]      a_data;
    logic            a_en;
    logic            a_er;
    logic            a_rise;
    logic            n_en;

    always_comb begin
        a_data = p2_data;
        a_en   = p2_en;
        a_er   = p2_er;
        n_en   = p1_en;
        a_rise = p2_en & ~p2_prev & p2_armed;
        if (active_p1) begin
            a_data = p1_data;
            a_en   = p1_en;
            a_er   = p1_er;
            n_en   = p2_en;
            a_rise = p1_en & ~p1_prev & p1_armed;
        end
    end

    // armed flags stay low after reset until en has been seen low, so a
    // frame already in flight at reset release is never taken as an edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tx_data   <= '0;
            tx_en     <= 1'b0;
            tx_er     <= 1'b0;
            active_p1 <= 1'b1;
            switched  <= 1'b0;
            truncated <= 1'b0;
            frame_cnt <= '0;
            gap_cnt   <= '0;
            p1_prev   <= 1'b0;
            p2_prev   <= 1'b0;
            p1_armed  <= 1'b0;
            p2_armed  <= 1'b0;
        end else begin
            p1_prev   <= p1_en;
            p2_prev   <= p2_en;
            p1_armed  <= p1_armed | ~p1_en;
            p2_armed  <= p2_armed | ~p2_en;
            tx_data   <= '0;
            tx_en     <= 1'b0;
            tx_er     <= 1'b0;
            switched  <= 1'b0;
            truncated <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (sel_p1 != active_p1) begin
                        active_p1 <= sel_p1;
                        switched  <= 1'b1;
                        gap_cnt   <= GAP_LOAD;
                        state     <= n_en ? ST_DRAIN : ST_GAP;
                    end else if (a_rise) begin
                        state     <= ST_PASS;
                        frame_cnt <= FW'(1);
                        tx_data   <= a_data;
                        tx_en     <= 1'b1;
                        tx_er     <= a_er;
                    end
                end
                ST_PASS: begin
                    if (!a_en) begin
                        state <= ST_IDLE;
                    end else begin
                        tx_data <= a_data;
                        tx_en   <= 1'b1;
                        tx_er   <= a_er;
                        if (frame_cnt != FRAME_MAX) begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                        // frame_cnt holds bytes already sent; this one is the last legal byte
                        if (frame_cnt >= FRAME_LAST) begin
                            tx_er     <= 1'b1;
                            truncated <= 1'b1;
                            state     <= ST_ABORT;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!a_en) begin
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (a_en) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= ST_DRAIN;
                    end else if (gap_cnt <= GAP_ONE) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                ST_ABORT: begin
                    if (!a_en) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_failover_tx_mux.sv
// Scoreboard bench for failover_tx_mux: a frame-level reference model predicts
// every output cycle; a monitor pops and compares one hour-glass entry per clock.
module tb_failover_tx_mux;

    localparam int IPG  = 12;
    localparam int MAXF = 1530;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_p1;
    logic [7:0] p1_data;
    logic       p1_en;
    logic       p1_er;
    logic [7:0] p2_data;
    logic       p2_en;
    logic       p2_er;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_er;
    logic       active_p1;
    logic       switched;
    logic       truncated;

    failover_tx_mux #(.IPG_CYCLES(IPG), .MAX_FRAME_CYCLES(MAXF)) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_p1    (sel_p1),
        .p1_data   (p1_data),
        .p1_en     (p1_en),
        .p1_er     (p1_er),
        .p2_data   (p2_data),
        .p2_en     (p2_en),
        .p2_er     (p2_er),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_er     (tx_er),
        .active_p1 (active_p1),
        .switched  (switched),
        .truncated (truncated)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       en;
        logic       er;
        logic       act;
        logic       sw;
        logic       tr;
    } exp_t;

    exp_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // reference model: frame-level bookkeeping, source index 0 = port 1
    bit m_act;
    bit m_fwd;
    bit m_drn;
    bit m_abt;
    int m_gap;
    int m_len;
    bit m_prev[2];
    bit m_arm[2];
    int tr_exp = 0;
    int sw_exp = 0;
    int tr_seen = 0;
    int sw_seen = 0;

    task automatic model_step();
        exp_t       e;
        int         a;
        int         n;
        bit         en[2];
        logic [7:0] dt[2];
        logic       er[2];
        en[0] = p1_en;   en[1] = p2_en;
        dt[0] = p1_data; dt[1] = p2_data;
        er[0] = p1_er;   er[1] = p2_er;
        e = '0;
        if (rst) begin
            m_act = 1'b1;
            m_fwd = 0; m_drn = 0; m_abt = 0; m_gap = 0; m_len = 0;
            for (int i = 0; i < 2; i++) begin
                m_prev[i] = 0;
                m_arm[i]  = 0;
            end
        end else begin
            a = m_act ? 0 : 1;
            if (m_fwd) begin
                if (!en[a]) m_fwd = 0;
                else begin
                    m_len++;
                    e.data = dt[a]; e.en = 1'b1; e.er = er[a];
                    if (m_len == MAXF) begin
                        e.er = 1'b1; e.tr = 1'b1; tr_exp++;
                        m_fwd = 0; m_abt = 1;
                    end
                end
            end else if (m_abt) begin
                if (!en[a]) m_abt = 0;
            end else if (m_drn) begin
                if (!en[a]) begin
                    m_drn = 0;
                    m_gap = IPG;
                end
            end else if (m_gap > 0) begin
                if (en[a]) begin
                    m_drn = 1;
                    m_gap = 0;
                end else m_gap--;
            end else if (sel_p1 != m_act) begin
                m_act = sel_p1;
                e.sw = 1'b1; sw_exp++;
                n = m_act ? 0 : 1;
                if (en[n]) m_drn = 1;
                else m_gap = IPG;
            end else if (en[a] && !m_prev[a] && m_arm[a]) begin
                m_fwd = 1; m_len = 1;
                e.data = dt[a]; e.en = 1'b1; e.er = er[a];
            end
            for (int i = 0; i < 2; i++) begin
                m_prev[i] = en[i];
                m_arm[i]  = m_arm[i] | !en[i];
            end
        end
        e.act = m_act;
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic s, input logic e1, input logic x1,
                         input logic e2, input logic x2);
        @(negedge clk);
        rst = r; sel_p1 = s;
        p1_en = e1; p1_er = x1; p1_data = 8'($urandom);
        p2_en = e2; p2_er = x2; p2_data = 8'($urandom);
        model_step();
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("tx_data",   tx_data,          e.data);
                chk("tx_en",     8'(tx_en),        8'(e.en));
                chk("tx_er",     8'(tx_er),        8'(e.er));
                chk("active_p1", 8'(active_p1),    8'(e.act));
                chk("switched",  8'(switched),     8'(e.sw));
                chk("truncated", 8'(truncated),    8'(e.tr));
                if (truncated === 1'b1) tr_seen++;
                if (switched === 1'b1)  sw_seen++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rem[2];
        int idl[2];
        bit en_r[2];
        bit s;
        int wait_cyc;

        rst = 1'b1; sel_p1 = 1'b1;
        p1_data = '0; p1_en = 0; p1_er = 0;
        p2_data = '0; p2_en = 0; p2_er = 0;
        repeat (3) drive(1, 1, 0, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 0, 0);

        // 64-byte port-1 frame with occasional er
        for (int i = 0; i < 64; i++) drive(0, 1, 1, (i == 40), 0, 0);
        repeat (5) drive(0, 1, 0, 0, 0, 0);

        // sel falls at byte 20 of a 100-byte frame: frame completes, then switch
        for (int i = 0; i < 100; i++) drive(0, (i < 20), 1, 0, 0, 0);
        repeat (20) drive(0, 0, 0, 0, 0, 0);

        // switch back to port 1, then to port 2 while a port-2 frame is at byte 30
        repeat (20) drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 60; i++) drive(0, (i < 30), 0, 0, 1, 1);
        repeat (15) drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 40; i++) drive(0, 0, 0, 0, 1, 0);
        repeat (5) drive(0, 0, 0, 0, 0, 0);

        // switch to port 1; a port-1 frame starting 5 cycles into the gap is discarded
        repeat (6) drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 1, 0, 0, 0);
        repeat (20) drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 0, 0);

        // overlong frame is cut at the length limit
        for (int i = 0; i < 2000; i++) drive(0, 1, 1, 0, 0, 0);
        repeat (5) drive(0, 1, 0, 0, 0, 0);

        // reset at byte 10 of a frame that keeps its en high afterwards
        for (int i = 0; i < 30; i++) drive((i == 10), 1, 1, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 1, 1, 0, 0, 0);
        repeat (3) drive(0, 1, 0, 0, 0, 0);

        // randomized dual-port traffic with source toggles and rare resets
        for (int i = 0; i < 2; i++) begin
            idl[i] = $urandom_range(1, 10);
            rem[i] = $urandom_range(1, 80);
        end
        s = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (idl[i] > 0) begin
                    en_r[i] = 0;
                    idl[i]--;
                end else begin
                    en_r[i] = 1;
                    rem[i]--;
                    if (rem[i] == 0) begin
                        idl[i] = $urandom_range(1, 20);
                        rem[i] = $urandom_range(1, 80);
                    end
                end
            end
            if ($urandom_range(0, 99) < 3) s = ~s;
            drive(($urandom_range(0, 599) == 0), s,
                  en_r[0], ($urandom_range(0, 15) == 0),
                  en_r[1], ($urandom_range(0, 15) == 0));
        end
        repeat (30) drive(0, s, 0, 0, 0, 0);

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        if (tr_seen != tr_exp) begin
            miscompares++;
            $display("FAIL truncated_count: got %0d expected %0d", tr_seen, tr_exp);
        end
        if (sw_seen != sw_exp) begin
            miscompares++;
            $display("FAIL switched_count: got %0d expected %0d", sw_seen, sw_exp);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
